// File: rtl/uart_pkg.sv
// Shared encodings for the SFR-mapped UART receiver: FSM states, status bit
// positions and synchroniser depth.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    localparam int STAT_RDY   = 0;
    localparam int STAT_OVR   = 1;
    localparam int STAT_FE    = 2;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO; pointers carry an extra wrap bit so full and empty
// are told apart by comparison alone. Used only when UART_RX_FIFO_EN is defined.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sfr_uart_rx.sv
// SFR-mapped 8N1 UART receiver with data and status registers on the r8051 SFR bus.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module sfr_uart_rx #(
    parameter logic [7:0] SFR_ADDRESS  = 8'h99,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ram_rd_en_sfr,
    input  logic [7:0] ram_rd_addr,
    output logic [7:0] sfr_rd_byte,
    output logic       sfr_rd_vld,
    output logic       rx_irq
);

    import uart_pkg::*;

    localparam int            CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT     = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]    STAT_ADDRESS = SFR_ADDRESS + 8'd1;

    logic [SYNC_DEPTH-1:0] sync;
    logic                  rx_s;
    rx_state_t             state;
    logic [CW-1:0]         cnt;
    logic [2:0]            bi;
    logic [7:0]            shift;
    logic                  armed;
    logic                  stop_tick;
    logic                  push;
    logic                  fe_evt;
    logic                  ovr_evt;
    logic                  rd_data_hit;
    logic                  rd_stat_hit;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [7:0]            head;
    logic                  ovr;
    logic                  fe;
    logic [7:0]            status;

    always_ff @(posedge clk) begin
        if (rst) sync <= '1;
        else     sync <= {sync[SYNC_DEPTH-2:0], rx};
    end
    assign rx_s = sync[SYNC_DEPTH-1];

    // armed is cleared on every start so a line held low (e.g. after a framing error) cannot retrigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            bi    <= '0;
            shift <= '0;
            armed <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (armed && !rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                        armed <= 1'b0;
                    end else if (rx_s) begin
                        armed <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_BIT) begin
                        cnt   <= '0;
                        bi    <= '0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        shift[bi] <= rx_s;
                        if (bi == 3'd7) state <= ST_STOP;
                        else            bi    <= bi + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stop_tick   = (state == ST_STOP) && (cnt == BIT_LAST);
    assign push        = stop_tick && rx_s;
    assign fe_evt      = stop_tick && !rx_s;
    assign rd_data_hit = ram_rd_en_sfr && (ram_rd_addr == SFR_ADDRESS);
    assign rd_stat_hit = ram_rd_en_sfr && (ram_rd_addr == STAT_ADDRESS);
    assign pop         = rd_data_hit && !empty;
    assign ovr_evt     = push && full && !pop;

`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shift),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
`else
    logic [7:0] hold;
    logic       hold_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= '0;
            hold_vld <= 1'b0;
        end else if (push && (!hold_vld || pop)) begin
            hold     <= shift;
            hold_vld <= 1'b1;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end

    assign full  = hold_vld;
    assign empty = !hold_vld;
    assign head  = hold;
`endif

    // A flag being set in the same cycle as its clear-on-read keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr <= 1'b0;
            fe  <= 1'b0;
        end else begin
            if (ovr_evt)          ovr <= 1'b1;
            else if (rd_stat_hit) ovr <= 1'b0;
            if (fe_evt)           fe  <= 1'b1;
            else if (rd_stat_hit) fe  <= 1'b0;
        end
    end

    always_comb begin
        status           = '0;
        status[STAT_RDY] = !empty;
        status[STAT_OVR] = ovr;
        status[STAT_FE]  = fe;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sfr_rd_byte <= '0;
            sfr_rd_vld  <= 1'b0;
        end else begin
            sfr_rd_vld <= rd_data_hit || rd_stat_hit;
            if (rd_stat_hit) sfr_rd_byte <= status;
            else if (pop)    sfr_rd_byte <= head;
            else             sfr_rd_byte <= 8'h00;
        end
    end

    assign rx_irq = !empty;

endmodule

// File: tb/tb_sfr_uart_rx.sv
// Self-checking bench for sfr_uart_rx: table of single-frame vectors plus
// hand-written sequences; read results are checked through an expectation queue.
module tb_sfr_uart_rx;

    localparam int BIT_CLKS = 16;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;
    localparam int NO_RST = 100000;
`ifdef UART_RX_FIFO_EN
    localparam int BUF_DEPTH = 4;
`else
    localparam int BUF_DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ram_rd_en_sfr = 1'b0;
    logic [7:0] ram_rd_addr = 8'h00;
    logic [7:0] sfr_rd_byte;
    logic       sfr_rd_vld;
    logic       rx_irq;

    int checks = 0;
    int errors = 0;
    logic rd_issued = 1'b0;
    logic [8:0] exp_q[$];
    string name_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_irq;
        logic [7:0] exp_stat;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    sfr_uart_rx #(
        .SFR_ADDRESS  (8'h99),
        .CLKS_PER_BIT (BIT_CLKS),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .ram_rd_en_sfr (ram_rd_en_sfr),
        .ram_rd_addr   (ram_rd_addr),
        .sfr_rd_byte   (sfr_rd_byte),
        .sfr_rd_vld    (sfr_rd_vld),
        .rx_irq        (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input string name, input logic vld, input logic [7:0] val);
        exp_q.push_back({vld, val});
        name_q.push_back(name);
    endtask

    always @(posedge clk) rd_issued <= ram_rd_en_sfr;

    always @(negedge clk) begin
        if (rd_issued) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_read: got vld=%0b byte=0x%0h, expected no read", sfr_rd_vld, sfr_rd_byte);
            end else begin
                automatic logic [8:0] e = exp_q.pop_front();
                automatic string n = name_q.pop_front();
                checkOutput({n, "_vld"}, int'(sfr_rd_vld), int'(e[8]));
                checkOutput({n, "_byte"}, int'(sfr_rd_byte), int'(e[7:0]));
            end
        end
    end

    task automatic applyStimulus(input string name, input logic [7:0] addr,
                                 input logic exp_vld, input logic [7:0] exp_val);
        ram_rd_en_sfr = 1'b1;
        ram_rd_addr   = addr;
        pushExp(name, exp_vld, exp_val);
        @(negedge clk);
        ram_rd_en_sfr = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stop_bit,
                             input int pop_at, input logic [7:0] pop_exp, input int rst_at);
        for (int c = 0; c < FRAME_CLKS; c++) begin
            int b;
            b = c / BIT_CLKS;
            if (b == 0)      rx = 1'b0;
            else if (b <= 8) rx = data[b-1];
            else             rx = stop_bit;
            rst = (c >= rst_at) && (c < rst_at + 2);
            if (c == pop_at) begin
                ram_rd_en_sfr = 1'b1;
                ram_rd_addr   = 8'h99;
                pushExp("coincident_pop", 1'b1, pop_exp);
            end else begin
                ram_rd_en_sfr = 1'b0;
            end
            @(negedge clk);
        end
        rx = 1'b1;
        rst = 1'b0;
        ram_rd_en_sfr = 1'b0;
    endtask

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL timeout: got no finish, expected finish within budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'h01, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h04, 8'h00};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h01, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'h01, 8'hFF};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 8'h04, 8'h00};

        repeat (3) @(negedge clk);
        checkOutput("reset_byte", int'(sfr_rd_byte), 0);
        checkOutput("reset_vld", int'(sfr_rd_vld), 0);
        checkOutput("reset_irq", int'(rx_irq), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus("reset_status", 8'h9A, 1'b1, 8'h00);

        $display("[TB] half-bit glitch on idle line");
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("glitch_irq", int'(rx_irq), 0);
        applyStimulus("glitch_status", 8'h9A, 1'b1, 8'h00);

        $display("[TB] single-frame vector table");
        for (int i = 0; i < 5; i++) begin
            sendFrame(vecs[i].data, vecs[i].stop_bit, -1, 8'h00, NO_RST);
            checkOutput("vec_irq", int'(rx_irq), int'(vecs[i].exp_irq));
            applyStimulus("vec_status", 8'h9A, 1'b1, vecs[i].exp_stat);
            applyStimulus("vec_data", 8'h99, 1'b1, vecs[i].exp_data);
            checkOutput("vec_irq_after_read", int'(rx_irq), 0);
            applyStimulus("vec_status_cleared", 8'h9A, 1'b1, 8'h00);
            applyStimulus("vec_other_addr", 8'h98, 1'b0, 8'h00);
            repeat (4) @(negedge clk);
        end

        $display("[TB] overrun with no reads");
        for (int i = 1; i <= BUF_DEPTH + 1; i++)
            sendFrame(8'(i * 8'h11 / (BUF_DEPTH == 1 ? 1 : 17)), 1'b1, -1, 8'h00, NO_RST);
        applyStimulus("ovr_status", 8'h9A, 1'b1, 8'h03);
        for (int i = 1; i <= BUF_DEPTH; i++)
            applyStimulus("ovr_data", 8'h99, 1'b1, 8'(i * 8'h11 / (BUF_DEPTH == 1 ? 1 : 17)));
        applyStimulus("ovr_drained", 8'h99, 1'b1, 8'h00);
        applyStimulus("ovr_status_cleared", 8'h9A, 1'b1, 8'h00);

        $display("[TB] reset during data bit 4");
        sendFrame(8'hFF, 1'b1, -1, 8'h00, 5 * BIT_CLKS + 6);
        repeat (4) @(negedge clk);
        checkOutput("midreset_irq", int'(rx_irq), 0);
        sendFrame(8'h5A, 1'b1, -1, 8'h00, NO_RST);
        applyStimulus("midreset_status", 8'h9A, 1'b1, 8'h01);
        applyStimulus("midreset_data", 8'h99, 1'b1, 8'h5A);

        $display("[TB] push coinciding with pop of a full buffer");
        for (int i = 0; i < BUF_DEPTH; i++)
            sendFrame(8'(8'h41 + i), 1'b1, -1, 8'h00, NO_RST);
        sendFrame(8'h77, 1'b1, 9 * BIT_CLKS + 10, 8'h41, NO_RST);
        applyStimulus("coincide_status", 8'h9A, 1'b1, 8'h01);
        for (int i = 1; i < BUF_DEPTH; i++)
            applyStimulus("coincide_drain", 8'h99, 1'b1, 8'(8'h41 + i));
        applyStimulus("coincide_data", 8'h99, 1'b1, 8'h77);
        applyStimulus("coincide_empty", 8'h9A, 1'b1, 8'h00);

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
